// File: rtl/i2c_mmio_bridge_pkg.sv
// Shared definitions for the I2C MMIO bridge: register map, bit positions,
// FIFO entry layouts and the issue FSM encoding.
package i2c_bridge_pkg;

   localparam int CMD_W = 16;
   localparam int RSP_W = 10;

   // Word offsets, compared against bus_addr[3:2]
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CMD    = 2'd2;
   localparam logic [1:0] REG_RSP    = 2'd3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_FLUSH  = 2;

   localparam int STAT_DONE     = 5;
   localparam int STAT_ERR_NACK = 6;
   localparam int STAT_ERR_TO   = 7;
   localparam int STAT_ERR_OVF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RETIRE = 2'd3
   } state_t;

   typedef struct packed {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
   } cmd_t;

   // Laid out to match RSP register bits [9:0]
   typedef struct packed {
      logic       data_nack;
      logic       addr_nack;
      logic [7:0] rdata;
   } rsp_t;

endpackage

// File: rtl/i2c_mmio_bridge_sync_fifo.sv
// Single-clock FIFO with synchronous clear, registered full/empty flags and
// show-ahead read data (pop_data is the current head whenever !empty).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count, count_next;
   logic             do_push, do_pop;

   // A push into a full FIFO is accepted only when the head leaves in the same cycle
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_comb begin
      // NOTE: default first so every path assigns count_next and no latch is inferred.
      count_next = count;
      if (do_push && !do_pop)
         count_next = count + (AW+1)'(1);
      else if (do_pop && !do_push)
         count_next = count - (AW+1)'(1);
   end

   always_ff @(posedge i_clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == (AW+1)'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define valid contents.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/i2c_mmio_bridge.sv
// MMIO front end for the I2C master: queues CPU commands, issues them one at a
// time over valid/ready, collects responses and status, and raises an IRQ.
module i2c_mmio_bridge
   import i2c_bridge_pkg::*;
#(
   parameter int CMD_DEPTH   = 4,
   parameter int RSP_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        i_clk,
   input  logic        reset,
   input  logic        bus_sel,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ready,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_rw,
   output logic [6:0]  cmd_addr,
   output logic [7:0]  cmd_wdata,
   input  logic        rsp_valid,
   input  logic [7:0]  rsp_rdata,
   input  logic        rsp_addr_nack,
   input  logic        rsp_data_nack,
   output logic        irq
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYC);

   state_t        state;
   logic [CW-1:0] wait_cnt;
   rsp_t          rsp_q;
   logic          timed_out;
   logic          enable, irq_en;
   logic          done, err_nack, err_timeout, err_overflow;

   cmd_t cmd_in, cmd_head;
   rsp_t rsp_head;
   logic cmd_full, cmd_empty, rsp_full, rsp_empty;
   logic wr_ctrl, wr_status, wr_cmd, rd_rsp, flush;
   logic issue_go, retire, any_nack, rsp_push, rsp_pop, busy;
   logic unused_bits;

   assign wr_ctrl   = bus_sel &  bus_we & (bus_addr[3:2] == REG_CTRL);
   assign wr_status = bus_sel &  bus_we & (bus_addr[3:2] == REG_STATUS);
   assign wr_cmd    = bus_sel &  bus_we & (bus_addr[3:2] == REG_CMD);
   assign rd_rsp    = bus_sel & ~bus_we & (bus_addr[3:2] == REG_RSP);
   assign flush     = wr_ctrl & bus_wdata[CTRL_FLUSH];
   assign cmd_in    = {bus_wdata[16], bus_wdata[14:8], bus_wdata[7:0]};

   // Reads are held back while the response FIFO has no room for their result
   assign issue_go = (state == ST_IDLE) & enable & ~cmd_empty & (~cmd_head.rw | ~rsp_full);
   assign retire   = (state == ST_RETIRE);
   assign any_nack = rsp_q.addr_nack | rsp_q.data_nack;
   assign rsp_push = retire & (cmd_rw | any_nack);
   assign rsp_pop  = rd_rsp & ~rsp_empty;
   assign busy     = (state != ST_IDLE);
   assign irq      = irq_en & (done | err_nack | err_timeout);

   assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:17], bus_wdata[15]};

   sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .i_clk     (i_clk),
      .reset     (reset),
      .clear     (flush),
      .push      (wr_cmd),
      .push_data (cmd_in),
      .pop       (issue_go),
      .pop_data  (cmd_head),
      .full      (cmd_full),
      .empty     (cmd_empty)
   );

   sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .i_clk     (i_clk),
      .reset     (reset),
      .clear     (flush),
      .push      (rsp_push),
      .push_data (rsp_q),
      .pop       (rsp_pop),
      .pop_data  (rsp_head),
      .full      (rsp_full),
      .empty     (rsp_empty)
   );

   always_ff @(posedge i_clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cmd_valid <= 1'b0;
         cmd_rw    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         wait_cnt  <= '0;
         rsp_q     <= '0;
         timed_out <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: if (issue_go) begin
               state     <= ST_ISSUE;
               cmd_valid <= 1'b1;
               cmd_rw    <= cmd_head.rw;
               cmd_addr  <= cmd_head.addr;
               cmd_wdata <= cmd_head.wdata;
            end
            ST_ISSUE: if (cmd_ready) begin
               state     <= ST_WAIT;
               cmd_valid <= 1'b0;
               wait_cnt  <= '0;
            end
            ST_WAIT: if (rsp_valid) begin
               state     <= ST_RETIRE;
               rsp_q     <= {rsp_data_nack, rsp_addr_nack, rsp_rdata};
               timed_out <= 1'b0;
            end else if (wait_cnt == TO_LIMIT) begin
               state     <= ST_RETIRE;
               rsp_q     <= '0;
               timed_out <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + CW'(1);
            end
            ST_RETIRE: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Sticky flags: a hardware set in the same cycle as a W1C wins
   always_ff @(posedge i_clk) begin
      if (reset) begin
         bus_ready    <= 1'b0;
         bus_rdata    <= '0;
         enable       <= 1'b0;
         irq_en       <= 1'b0;
         done         <= 1'b0;
         err_nack     <= 1'b0;
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         bus_ready <= bus_sel;
         if (wr_ctrl) begin
            enable <= bus_wdata[CTRL_EN];
            irq_en <= bus_wdata[CTRL_IRQ_EN];
         end
         done         <= retire | (done & ~(wr_status & bus_wdata[STAT_DONE]));
         err_nack     <= (retire & any_nack) | (err_nack & ~(wr_status & bus_wdata[STAT_ERR_NACK]));
         err_timeout  <= (retire & timed_out) | (err_timeout & ~(wr_status & bus_wdata[STAT_ERR_TO]));
         err_overflow <= (wr_cmd & cmd_full & ~issue_go) |
                         (err_overflow & ~(wr_status & bus_wdata[STAT_ERR_OVF]));

         bus_rdata <= '0;
         if (bus_sel && !bus_we) begin
            unique case (bus_addr[3:2])
               REG_CTRL:   bus_rdata <= {30'b0, irq_en, enable};
               REG_STATUS: bus_rdata <= {23'b0, err_overflow, err_timeout, err_nack, done,
                                         rsp_full, rsp_empty, cmd_empty, cmd_full, busy};
               REG_RSP:    if (!rsp_empty) bus_rdata <= {1'b1, 21'b0, rsp_head};
               default:    bus_rdata <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_mmio_bridge.sv
// Self-checking bench for i2c_mmio_bridge: table-driven transactions with
// command/response scoreboards, plus hand-written multi-cycle corner cases.
module tb_i2c_mmio_bridge;

   logic        i_clk = 1'b0;
   logic        reset = 1'b1;
   logic        bus_sel = 1'b0, bus_we = 1'b0;
   logic [3:0]  bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   logic        cmd_valid, cmd_rw;
   logic        cmd_ready = 1'b0;
   logic [6:0]  cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid = 1'b0;
   logic [7:0]  rsp_rdata = '0;
   logic        rsp_addr_nack = 1'b0, rsp_data_nack = 1'b0;
   logic        irq;

   localparam logic [3:0] A_CTRL = 4'h0, A_STATUS = 4'h4, A_CMD = 4'h8, A_RSP = 4'hC;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_cmd_q[$];
   logic [31:0] exp_rsp_q[$];

   typedef struct {
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  rd;
      logic        an;
      logic        dn;
      logic        has_rsp;
      logic [31:0] exp_rsp;
      logic        exp_err;
   } vec_t;
   vec_t vecs[5];

   always #5 i_clk = ~i_clk;

   i2c_mmio_bridge #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYC(1024)) dut (
      .i_clk         (i_clk),
      .reset         (reset),
      .bus_sel       (bus_sel),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_ready     (bus_ready),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_rw        (cmd_rw),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_addr_nack (rsp_addr_nack),
      .rsp_data_nack (rsp_data_nack),
      .irq           (irq)
   );

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      tick();
      bus_sel = 1'b0; bus_we = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
      tick();
      d = bus_rdata;
      bus_sel = 1'b0;
   endtask

   task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d, input bit expect_issue);
      bus_write(A_CMD, {15'b0, rw, 1'b0, a, d});
      if (expect_issue) exp_cmd_q.push_back({rw, a, d});
   endtask

   // Bounded wait for cmd_valid, then compare the presented command with the scoreboard head
   task automatic wait_issue();
      int n = 0;
      while (!cmd_valid && n < 64) begin
         tick();
         n++;
      end
      check("issue_valid", 32'(cmd_valid), 32'd1);
      if (exp_cmd_q.size() == 0)
         check("cmd_unexpected", 32'({cmd_rw, cmd_addr, cmd_wdata}), 32'hFFFF_FFFF);
      else
         check("cmd_fields", 32'({cmd_rw, cmd_addr, cmd_wdata}), 32'(exp_cmd_q.pop_front()));
   endtask

   task automatic complete(input logic [7:0] rd, input logic an, input logic dn);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("valid_drop", 32'(cmd_valid), 32'd0);
      tick();
      tick();
      rsp_valid = 1'b1; rsp_rdata = rd; rsp_addr_nack = an; rsp_data_nack = dn;
      tick();
      rsp_valid = 1'b0; rsp_rdata = '0; rsp_addr_nack = 1'b0; rsp_data_nack = 1'b0;
      tick();
      tick();
   endtask

   task automatic drain_rsp();
      logic [31:0] d;
      while (exp_rsp_q.size() > 0) begin
         bus_read(A_RSP, d);
         check("rsp_word", d, exp_rsp_q.pop_front());
      end
      bus_read(A_RSP, d);
      check("rsp_empty_read", d, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int n;

      vecs[0] = '{1'b1, 7'h51, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, 32'h8000_003C, 1'b0};
      vecs[1] = '{1'b0, 7'h20, 8'h11, 8'h00, 1'b1, 1'b0, 1'b1, 32'h8000_0100, 1'b1};
      vecs[2] = '{1'b1, 7'h7F, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 32'h8000_02FF, 1'b1};
      vecs[3] = '{1'b0, 7'h00, 8'h5A, 8'h77, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
      vecs[4] = '{1'b1, 7'h2A, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 32'h8000_0300, 1'b1};

      // Reset state
      repeat (3) tick();
      check("rst_bus_ready", 32'(bus_ready), 32'd0);
      check("rst_bus_rdata", bus_rdata, 32'd0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_regs", 32'({cmd_rw, cmd_addr, cmd_wdata}), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      tick();
      bus_read(A_STATUS, d); check("rst_status", d, 32'h0000_000C);
      bus_read(A_CTRL, d);   check("rst_ctrl", d, 32'd0);

      // Single write: issue latency, fields, completion latency
      bus_write(A_CTRL, 32'h3);
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = A_CMD; bus_wdata = 32'h0000_50A5;
      tick();
      bus_sel = 1'b0; bus_we = 1'b0;
      check("t1_bus_ready", 32'(bus_ready), 32'd1);
      check("t1_lat_cyc1", 32'(cmd_valid), 32'd0);
      tick();
      check("t1_ready_pulse", 32'(bus_ready), 32'd0);
      check("t1_lat_cyc2", 32'(cmd_valid), 32'd1);
      check("t1_cmd", 32'({cmd_rw, cmd_addr, cmd_wdata}), 32'h0000_50A5);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      tick();
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
      check("t1_done_lat1", 32'(irq), 32'd0);
      tick();
      check("t1_done_lat2", 32'(irq), 32'd1);
      bus_read(A_STATUS, d); check("t1_status", d, 32'h0000_002C);
      bus_read(A_RSP, d);    check("t1_rsp_none", d, 32'd0);
      bus_write(A_STATUS, 32'hE0);

      // Table-driven transactions
      for (int i = 0; i < 5; i++) begin
         push_cmd(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b1);
         wait_issue();
         complete(vecs[i].rd, vecs[i].an, vecs[i].dn);
         if (vecs[i].has_rsp) exp_rsp_q.push_back(vecs[i].exp_rsp);
         bus_read(A_STATUS, d);
         check($sformatf("vec%0d_status", i), d,
               32'h24 | (vecs[i].exp_err ? 32'h40 : 32'h0) | (vecs[i].has_rsp ? 32'h0 : 32'h08));
         check($sformatf("vec%0d_irq", i), 32'(irq), 32'd1);
         drain_rsp();
         bus_write(A_STATUS, 32'hE0);
         check($sformatf("vec%0d_irq_clr", i), 32'(irq), 32'd0);
      end

      // Overflow with enable low, then in-order drain
      bus_write(A_CTRL, 32'h2);
      for (int i = 0; i < 5; i++) push_cmd(1'b0, 7'(16 + i), 8'(i), i < 4);
      check("t3_no_issue", 32'(cmd_valid), 32'd0);
      bus_read(A_STATUS, d); check("t3_full_ovf", d, 32'h0000_010A);
      bus_write(A_CTRL, 32'h3);
      for (int i = 0; i < 4; i++) begin
         wait_issue();
         complete(8'h00, 1'b0, 1'b0);
      end
      bus_read(A_STATUS, d); check("t3_drained", d, 32'h0000_012C);
      bus_write(A_STATUS, 32'h1E0);

      // Timeout: ready held, response withheld
      push_cmd(1'b1, 7'h33, 8'h00, 1'b1);
      cmd_ready = 1'b1;
      wait_issue();
      tick();
      n = 0;
      while (!irq && n < 1200) begin
         tick();
         n++;
      end
      cmd_ready = 1'b0;
      check("t4_irq", 32'(irq), 32'd1);
      check("t4_latency_window", 32'(n >= 1020 && n <= 1030), 32'd1);
      exp_rsp_q.push_back(32'h8000_0000);
      bus_read(A_STATUS, d); check("t4_status", d, 32'h0000_00A4);
      drain_rsp();
      bus_write(A_STATUS, 32'hE0);

      // Flush empties queued commands; flush bit is not stored
      bus_write(A_CTRL, 32'h2);
      push_cmd(1'b0, 7'h11, 8'h22, 1'b0);
      push_cmd(1'b0, 7'h12, 8'h23, 1'b0);
      bus_read(A_STATUS, d); check("flush_before", d, 32'h0000_0008);
      bus_write(A_CTRL, 32'h6);
      bus_read(A_STATUS, d); check("flush_after", d, 32'h0000_000C);
      bus_read(A_CTRL, d);   check("flush_ctrl", d, 32'h0000_0002);
      bus_write(A_CTRL, 32'h3);

      // Response FIFO back-pressure on reads, then reset during ISSUE
      for (int i = 0; i < 4; i++) begin
         push_cmd(1'b1, 7'(32 + i), 8'h00, 1'b1);
         wait_issue();
         complete(8'(192 + i), 1'b0, 1'b0);
         exp_rsp_q.push_back(32'h8000_00C0 + 32'(i));
      end
      push_cmd(1'b1, 7'h45, 8'h00, 1'b1);
      repeat (6) tick();
      check("t6_held", 32'(cmd_valid), 32'd0);
      bus_read(A_STATUS, d); check("t6_status_full", d, 32'h0000_0030);
      bus_read(A_RSP, d);    check("t6_pop", d, exp_rsp_q.pop_front());
      wait_issue();
      push_cmd(1'b0, 7'h46, 8'h99, 1'b0);
      reset = 1'b1;
      tick();
      check("t6_rst_valid", 32'(cmd_valid), 32'd0);
      check("t6_rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      exp_rsp_q.delete();
      exp_cmd_q.delete();
      bus_read(A_STATUS, d); check("t6_rst_status", d, 32'h0000_000C);
      bus_read(A_CTRL, d);   check("t6_rst_ctrl", d, 32'd0);
      bus_read(A_RSP, d);    check("t6_rst_rsp", d, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
